// File: rtl/bar_field_gen_if.sv
// rtl/bar_field_gen_if.sv - control inputs and snapshot outputs of the bar field generator
interface bar_field_gen_if #(
   parameter int NUM_BARS = 8,
   parameter int POS_W    = 10
);
   logic                      pause;
   logic                      step;
   logic                      mode;
   logic [9:0]                level;
   logic [NUM_BARS*POS_W-1:0] bar_pos;
   logic [NUM_BARS*POS_W-1:0] bar_op;
   logic                      busy;
   logic                      frame_done;
   logic                      level_chg;
   logic                      overrun;

   modport master (
      output pause, step, mode, level,
      input  bar_pos, bar_op, busy, frame_done, level_chg, overrun
   );

   modport slave (
      input  pause, step, mode, level,
      output bar_pos, bar_op, busy, frame_done, level_chg, overrun
   );
endinterface

// File: rtl/bar_field_gen.sv
// rtl/bar_field_gen.sv - scrolling obstacle-bar generator, one bar per clock,
// publishing a coherent position/opening snapshot after each sweep.
module bar_field_gen #(
   parameter int NUM_BARS  = 8,
   parameter int POS_W     = 10,
   parameter int SCREEN_H  = 480,
   parameter int OPEN_BASE = 60,
   parameter int OPEN_STEP = 20
) (
   input logic            clkenv,
   input logic            rst_n,
   bar_field_gen_if.slave bus
);
   localparam int IDX_W = (NUM_BARS > 1) ? $clog2(NUM_BARS) : 1;
   localparam int AW    = POS_W + 2;

   typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_PUBLISH, S_LOAD} state_t;

   state_t                    state_q, state_d;
   logic [IDX_W-1:0]          idx_q;
   logic [9:0]                level_q;
   logic [POS_W-1:0]          pos_q [NUM_BARS];
   logic                      dir_q [NUM_BARS];
   logic [NUM_BARS*POS_W-1:0] out_pos_q;
   logic [NUM_BARS*POS_W-1:0] out_op_q;
   logic                      frame_done_q;
   logic                      level_chg_q;
   logic                      overrun_q;

   function automatic logic [1:0] group_of(input logic [9:0] lvl);
      return 2'(lvl + 10'd3);
   endfunction

   function automatic logic [POS_W-1:0] open_of(input logic [1:0] g);
      return POS_W'(OPEN_BASE + OPEN_STEP * int'(g));
   endfunction

   function automatic logic [POS_W-1:0] init_pos(input int i);
      return (i % 2 == 0) ? POS_W'(SCREEN_H / 2) : POS_W'(SCREEN_H / 4);
   endfunction

   logic                 lvl_mismatch;
   logic [1:0]           grp_q;
   logic [POS_W-1:0]     open_cur;
   logic [POS_W-1:0]     open_new;
   int                   mag;
   logic signed [AW-1:0] speed;
   logic signed [AW-1:0] next_pos;
   logic signed [AW-1:0] max_top;
   logic [POS_W-1:0]     upd_pos;
   logic                 upd_flip;

   // LOAD itself never re-triggers; a further change is seen once level_q catches up.
   assign lvl_mismatch = (bus.level != level_q) && (state_q != S_LOAD);
   assign grp_q        = group_of(level_q);
   assign open_cur     = open_of(grp_q);
   assign open_new     = open_of(group_of(bus.level));

   always_comb begin
      mag      = 5 * (int'(grp_q) + 1) + 5 * (int'(idx_q) % 3);
      speed    = (idx_q[0] ^ dir_q[idx_q]) ? -AW'(mag) : AW'(mag);
      next_pos = $signed({2'b00, pos_q[idx_q]}) + speed;
      max_top  = AW'(SCREEN_H) - AW'(open_cur);
      upd_pos  = next_pos[POS_W-1:0];
      upd_flip = 1'b0;
      if (next_pos[AW-1]) begin
         upd_pos  = bus.mode ? '0 : max_top[POS_W-1:0];
         upd_flip = bus.mode;
      end else if (next_pos > max_top) begin
         upd_pos  = bus.mode ? max_top[POS_W-1:0] : '0;
         upd_flip = bus.mode;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (bus.step && !bus.pause) state_d = S_SWEEP;
         S_SWEEP:   if (idx_q == IDX_W'(NUM_BARS - 1)) state_d = S_PUBLISH;
         S_PUBLISH: state_d = S_IDLE;
         S_LOAD:    state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
      if (lvl_mismatch) state_d = S_LOAD;
   end

   always_ff @(posedge clkenv or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         idx_q        <= '0;
         level_q      <= 10'd1;
         frame_done_q <= 1'b0;
         level_chg_q  <= 1'b0;
         overrun_q    <= 1'b0;
         for (int i = 0; i < NUM_BARS; i++) begin
            pos_q[i]                      <= init_pos(i);
            dir_q[i]                      <= 1'b0;
            out_pos_q[i*POS_W +: POS_W]   <= init_pos(i);
            out_op_q[i*POS_W +: POS_W]    <= POS_W'(OPEN_BASE);
         end
      end else begin
         state_q      <= state_d;
         frame_done_q <= (state_q == S_PUBLISH) && !lvl_mismatch;
         level_chg_q  <= (state_q == S_LOAD);
         overrun_q    <= bus.step && !lvl_mismatch && (state_q != S_IDLE);
         case (state_q)
            S_IDLE: idx_q <= '0;
            S_SWEEP: begin
               if (!lvl_mismatch) begin
                  pos_q[idx_q] <= upd_pos;
                  dir_q[idx_q] <= dir_q[idx_q] ^ upd_flip;
                  idx_q        <= idx_q + IDX_W'(1);
               end
            end
            S_PUBLISH: begin
               if (!lvl_mismatch) begin
                  for (int i = 0; i < NUM_BARS; i++) begin
                     out_pos_q[i*POS_W +: POS_W] <= pos_q[i];
                     out_op_q[i*POS_W +: POS_W]  <= open_cur;
                  end
               end
            end
            S_LOAD: begin
               level_q <= bus.level;
               idx_q   <= '0;
               for (int i = 0; i < NUM_BARS; i++) begin
                  pos_q[i]                    <= init_pos(i);
                  dir_q[i]                    <= 1'b0;
                  out_pos_q[i*POS_W +: POS_W] <= init_pos(i);
                  out_op_q[i*POS_W +: POS_W]  <= open_new;
               end
            end
            default: idx_q <= '0;
         endcase
      end
   end

   assign bus.bar_pos    = out_pos_q;
   assign bus.bar_op     = out_op_q;
   assign bus.busy       = (state_q == S_SWEEP) || (state_q == S_PUBLISH);
   assign bus.frame_done = frame_done_q;
   assign bus.level_chg  = level_chg_q;
   assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_bar_field_gen.sv
// tb/tb_bar_field_gen.sv - bench for bar_field_gen: frame-level reference model
// compared every cycle, plus literal expectations taken from the bar rules.
module tb_bar_field_gen;
   localparam int NB = 4;
   localparam int PW = 10;
   localparam int SH = 480;
   localparam int OB = 60;
   localparam int OS = 20;

   logic clk;
   logic rst_n;

   bar_field_gen_if #(.NUM_BARS(NB), .POS_W(PW)) bus ();

   bar_field_gen #(
      .NUM_BARS(NB), .POS_W(PW), .SCREEN_H(SH), .OPEN_BASE(OB), .OPEN_STEP(OS)
   ) dut (
      .clkenv (clk),
      .rst_n  (rst_n),
      .bus    (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   bit cmp_on   = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // Reference model: whole frames computed at once from the bar rules.
   int m_pos [NB];
   int m_dir [NB];
   int s_pos [NB];
   int s_op;
   int m_level;
   int busy_left;
   bit load_pend, e_fd, e_lc, e_ov;

   function automatic int grp(input int lvl);
      return (lvl + 3) % 4;
   endfunction

   function automatic int init_p(input int i);
      return (i % 2 == 0) ? SH / 2 : SH / 4;
   endfunction

   task automatic model_load(input int lvl);
      m_level = lvl;
      for (int i = 0; i < NB; i++) begin
         m_pos[i] = init_p(i);
         m_dir[i] = 1;
         s_pos[i] = m_pos[i];
      end
      s_op = OB + OS * grp(lvl);
   endtask

   task automatic model_reset();
      model_load(1);
      busy_left = 0;
      load_pend = 1'b0;
      e_fd = 1'b0; e_lc = 1'b0; e_ov = 1'b0;
   endtask

   task automatic model_frame(input bit md);
      int g, op, mt, mag, sp, nx;
      g  = grp(m_level);
      op = OB + OS * g;
      mt = SH - op;
      for (int i = 0; i < NB; i++) begin
         mag = 5 * (g + 1) + 5 * (i % 3);
         sp  = ((i % 2 == 0) ? mag : -mag) * m_dir[i];
         nx  = m_pos[i] + sp;
         if (nx > mt) begin
            m_pos[i] = md ? mt : 0;
            if (md) m_dir[i] = -m_dir[i];
         end else if (nx < 0) begin
            m_pos[i] = md ? 0 : mt;
            if (md) m_dir[i] = -m_dir[i];
         end else begin
            m_pos[i] = nx;
         end
         s_pos[i] = m_pos[i];
      end
      s_op = op;
   endtask

   always @(posedge clk) begin
      if (rst_n) begin
         e_fd = 1'b0; e_lc = 1'b0; e_ov = 1'b0;
         if (load_pend) begin
            model_load(int'(bus.level));
            e_lc      = 1'b1;
            e_ov      = bus.step;
            load_pend = 1'b0;
         end else if (int'(bus.level) != m_level) begin
            load_pend = 1'b1;
            busy_left = 0;
         end else if (busy_left > 0) begin
            e_ov = bus.step;
            busy_left--;
            if (busy_left == 0) begin
               model_frame(bus.mode);
               e_fd = 1'b1;
            end
         end else if (bus.step && !bus.pause) begin
            busy_left = NB + 1;
         end
      end
   end

   always @(negedge clk) begin
      logic [NB*PW-1:0] ep, eo;
      if (cmp_on) begin
         for (int i = 0; i < NB; i++) begin
            ep[i*PW +: PW] = PW'(s_pos[i]);
            eo[i*PW +: PW] = PW'(s_op);
         end
         chk("cyc_busy", bus.busy, busy_left > 0);
         chk("cyc_frame_done", bus.frame_done, e_fd);
         chk("cyc_level_chg", bus.level_chg, e_lc);
         chk("cyc_overrun", bus.overrun, e_ov);
         chk("cyc_bar_pos", bus.bar_pos, ep);
         chk("cyc_bar_op", bus.bar_op, eo);
      end
   end

   int c_busy, c_fd, c_lc, c_ov;
   always @(negedge clk) begin
      if (rst_n) begin
         c_busy += int'(bus.busy);
         c_fd   += int'(bus.frame_done);
         c_lc   += int'(bus.level_chg);
         c_ov   += int'(bus.overrun);
      end
   end

   task automatic clr_cnt();
      c_busy = 0; c_fd = 0; c_lc = 0; c_ov = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   function automatic logic [63:0] pack4(input int a, input int b, input int c, input int d);
      logic [NB*PW-1:0] v;
      v = {PW'(d), PW'(c), PW'(b), PW'(a)};
      return 64'(v);
   endfunction

   function automatic int bar(input int i);
      return int'(bus.bar_pos[i*PW +: PW]);
   endfunction

   task automatic do_step(input bit p);
      bus.step  = 1'b1;
      bus.pause = p;
      tick();
      bus.step  = 1'b0;
      bus.pause = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (bus.busy && n < 30) begin
         tick();
         n++;
      end
      chk("frame_timeout", bus.busy, 1'b0);
      tick();
   endtask

   task automatic run_frame();
      do_step(1'b0);
      wait_idle();
   endtask

   task automatic reset_dut();
      rst_n = 1'b0;
      model_reset();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      bus.step  = 1'b0;
      bus.pause = 1'b0;
      bus.mode  = 1'b0;
      bus.level = 10'd1;
      model_reset();
      repeat (3) tick();
      cmp_on = 1'b1;
      rst_n  = 1'b1;
      clr_cnt();
      tick(); tick();

      chk("reset_pos", bus.bar_pos, pack4(240, 120, 240, 120));
      chk("reset_op", bus.bar_op, pack4(60, 60, 60, 60));
      chk("reset_no_level_chg", c_lc, 0);

      clr_cnt();
      run_frame();
      chk("step1_pos", bus.bar_pos, pack4(245, 110, 255, 115));
      chk("step1_busy_cycles", c_busy, 5);
      chk("step1_frame_done", c_fd, 1);

      reset_dut();
      for (int s = 1; s <= 37; s++) begin
         run_frame();
         if (s == 12) chk("wrap_bar1_s12", bar(1), 0);
         if (s == 13) chk("wrap_bar1_s13", bar(1), 420);
         if (s == 36) chk("wrap_bar0_s36", bar(0), 420);
         if (s == 37) chk("wrap_bar0_s37", bar(0), 0);
      end

      reset_dut();
      bus.mode = 1'b1;
      for (int s = 1; s <= 38; s++) begin
         run_frame();
         if (s == 13) chk("bounce_bar1_s13", bar(1), 0);
         if (s == 14) chk("bounce_bar1_s14", bar(1), 10);
         if (s == 37) chk("bounce_bar0_s37", bar(0), 420);
         if (s == 38) chk("bounce_bar0_s38", bar(0), 415);
      end

      bus.mode = 1'b0;
      reset_dut();
      clr_cnt();
      do_step(1'b0);
      tick();
      bus.level = 10'd2;
      repeat (4) tick();
      chk("lvl2_level_chg", c_lc, 1);
      chk("lvl2_no_frame_done", c_fd, 0);
      chk("lvl2_pos", bus.bar_pos, pack4(240, 120, 240, 120));
      chk("lvl2_op", bus.bar_op, pack4(80, 80, 80, 80));
      run_frame();
      chk("lvl2_step_pos", bus.bar_pos, pack4(250, 105, 260, 110));

      clr_cnt();
      do_step(1'b0);
      tick();
      bus.step = 1'b1;
      tick();
      bus.step = 1'b0;
      wait_idle();
      chk("overrun_pulses", c_ov, 1);
      chk("overrun_frames", c_fd, 1);
      chk("overrun_pos", bus.bar_pos, pack4(260, 90, 280, 100));

      clr_cnt();
      do_step(1'b1);
      repeat (3) tick();
      chk("pause_busy", c_busy, 0);
      chk("pause_frames", c_fd, 0);
      chk("pause_pos", bus.bar_pos, pack4(260, 90, 280, 100));

      clr_cnt();
      bus.level = 10'd3;
      bus.step  = 1'b1;
      tick();
      bus.step  = 1'b0;
      repeat (3) tick();
      chk("lvl3_level_chg", c_lc, 1);
      chk("lvl3_no_overrun", c_ov, 0);
      chk("lvl3_no_busy", c_busy, 0);
      chk("lvl3_op", bus.bar_op, pack4(100, 100, 100, 100));

      run_frame();
      do_step(1'b0);
      tick();
      rst_n     = 1'b0;
      bus.level = 10'd1;
      model_reset();
      #1;
      chk("midsweep_reset_busy", bus.busy, 1'b0);
      chk("midsweep_reset_pos", bus.bar_pos, pack4(240, 120, 240, 120));
      chk("midsweep_reset_op", bus.bar_op, pack4(60, 60, 60, 60));
      tick();
      rst_n = 1'b1;
      clr_cnt();
      repeat (3) tick();
      chk("post_reset_quiet", c_lc + c_fd + c_busy, 0);

      cmp_on = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
